// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side handshake bundle for the shared memory port.
// slave is the arbiter's view; master is the view of the caches and memory together.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [32*NUM_REQ-1:0] req_addr;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [31:0]           req_rdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_req;
    logic                  mem_write;
    logic [31:0]           mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_rdata, req_ready, mem_addr, mem_wdata, mem_req, mem_write
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_rdata, req_ready, mem_addr, mem_wdata, mem_req, mem_write
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one memory port between NUM_REQ caches, with a stall watchdog.
// Grant one cycle after request; req_ready is combinational on mem_ready; one bubble between grants.
module mem_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 timeout_err,
    output logic [15:0]          timeout_count
);
    typedef enum logic {ARB, GRANT} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr, rr_ptr_nxt, grant_nxt, pick, ptr_inc, idx;
    logic [15:0]     wait_cnt, wait_cnt_nxt;
    logic            any_req, abort, gnt_valid, timeout_hit;

    // Cyclic priority search starting at rr_ptr; iterating downward lets the nearest set bit win.
    always_comb begin
        pick    = rr_ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
        end
    end

    assign ptr_inc     = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + IDW'(1);
    assign gnt_valid   = bus.req_valid[grant_id];
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == 16'(TIMEOUT - 1));

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_id;
        rr_ptr_nxt   = rr_ptr;
        wait_cnt_nxt = wait_cnt;
        abort        = 1'b0;
        case (state)
            ARB: begin
                wait_cnt_nxt = '0;
                if (any_req) begin
                    grant_nxt = pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Completion and requester drop both release the port the same way.
                if (!gnt_valid || bus.mem_ready) begin
                    state_nxt  = ARB;
                    rr_ptr_nxt = ptr_inc;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_nxt  = ARB;
                    rr_ptr_nxt = ptr_inc;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARB;
            rr_ptr        <= '0;
            grant_id      <= '0;
            wait_cnt      <= '0;
            timeout_err   <= 1'b0;
            timeout_count <= '0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            grant_id    <= grant_nxt;
            wait_cnt    <= wait_cnt_nxt;
            timeout_err <= abort;
            if (abort && timeout_count != 16'hFFFF)
                timeout_count <= timeout_count + 16'd1;
        end
    end

    assign busy          = (state == GRANT);
    assign bus.mem_req   = busy & gnt_valid;
    assign bus.mem_write = busy & bus.req_write[grant_id];
    assign bus.mem_addr  = busy ? bus.req_addr[32*grant_id +: 32]  : 32'd0;
    assign bus.mem_wdata = busy ? bus.req_wdata[32*grant_id +: 32] : 32'd0;
    assign bus.req_rdata = bus.mem_rdata;
    assign bus.req_ready = (bus.mem_req && bus.mem_ready) ? (NUM_REQ'(1) << grant_id) : '0;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single main-memory port between `NUM_REQ` cache controllers (for example I-cache and D-cache), each using the cache memory handshake (`req`/`write`/`addr`/`wdata` held until `ready`). It sits between the caches' memory-side ports and the memory interface. It grants one requester at a time and holds the grant until memory completes the transaction. A watchdog aborts transactions that stall.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `TIMEOUT`, 255: max cycles a granted transaction may wait for `mem_ready`; 0 disables the watchdog.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester memory request; held high until its `req_ready`.
- `req_write`  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- `req_addr`  in  32*NUM_REQ  flattened addresses; requester i uses bits [32i+31:32i].
- `req_wdata`  in  32*NUM_REQ  flattened write data, same packing.
- `req_rdata`  out  32  `mem_rdata` broadcast to all requesters.
- `req_ready`  out  NUM_REQ  one-hot completion strobe to the granted requester.
- `mem_addr`, `mem_wdata`  out  32 each  granted requester's address and data.
- `mem_req`, `mem_write`  out  1 each  memory request and direction.
- `mem_rdata`  in  32  memory read data.
- `mem_ready`  in  1  memory completion strobe.
- `busy`  out  1  a grant is active.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- `timeout_err`  out  1  one-cycle pulse when the watchdog aborts a transaction.
- `timeout_count`  out  16  saturating count of watchdog aborts.

## Operation
- FSM has two states: ARB and GRANT. Reset state is ARB.
- **ARB:**
  - If no `req_valid` bit is set, stay in ARB.
  - Otherwise register `grant_id` as the first set bit at or after `rr_ptr`, searching cyclically, and go to GRANT.
  - Clear the wait counter.
- **GRANT:**
  - Drive the `mem_*` outputs combinationally from requester `grant_id`: `mem_req = req_valid[grant_id]`, `mem_write`, `mem_addr`, `mem_wdata`.
  - `busy = 1`.
  - `req_rdata = mem_rdata` at all times.
  - `req_ready[grant_id] = mem_ready & mem_req`. All other `req_ready` bits are 0.
- **Completion:** `mem_ready` in GRANT completes the transaction.
  - Set `rr_ptr` to `grant_id+1`, wrapping from NUM_REQ-1 to 0.
  - Go to ARB.
- **Drop:** if `req_valid[grant_id]` deasserts in GRANT without `mem_ready`:
  - `mem_req` drops the same cycle, and the FSM goes to ARB.
  - `rr_ptr` advances as for a completion.
  - Any `mem_ready` seen while in ARB is ignored.
- **Watchdog:**
  - The wait counter increments each GRANT cycle without `mem_ready`.
  - When it reaches `TIMEOUT`, the next cycle:
    - pulse `timeout_err`;
    - increment `timeout_count`, saturating at 0xFFFF;
    - force ARB;
    - advance `rr_ptr`.
  - The aborted requester receives no `req_ready`.
- `mem_*` outputs are 0 in ARB. There is no buffering; one transaction is outstanding at a time.
- A requester that issues back-to-back transactions (writeback then allocate) re-arbitrates between them. Other pending requesters win that arbitration because of the round-robin order.

## Timing
- **Reset values:** state ARB, `rr_ptr=0`, `grant_id=0`, `busy=0`, `mem_req=0`, `mem_write=0`, `mem_addr=0`, `mem_wdata=0`, `req_ready=0`, `timeout_err=0`, `timeout_count=0`. `req_rdata` follows `mem_rdata`.
- **Grant latency:** `req_valid` high in cycle t (FSM in ARB) → `mem_req` high in cycle t+1.
- **Completion:** `mem_ready` in cycle c → `req_ready` in cycle c (combinational). ARB in c+1; next `mem_req` earliest at c+2. One-cycle bubble between transactions.
- **Simultaneous requests:** the `rr_ptr` order decides. The loser waits, with no limit other than `NUM_REQ-1` grants ahead of it.
- **Reset mid-GRANT:** all outputs drop immediately (asynchronous). No `req_ready` is produced.

## Test plan
- **Single read:** requester 0 reads 0x0000_0040; memory returns 0xDEADBEEF after 3 cycles → `mem_req` high 1 cycle after `req_valid`. `req_ready=2'b01` and `req_rdata=0xDEADBEEF` in the same cycle as `mem_ready`.
- **Contention:** both requesters assert in the same cycle after reset → requester 0 is served first, then requester 1 with exactly one idle cycle between. `rr_ptr` ends at 0.
- **Fairness:** requester 0 continuously re-requests while requester 1 holds its request → grants alternate 0,1,0,1. Requester 1 never waits more than one transaction.
- **Write:** requester 1 writes 0xA5A5_0001 to 0x0000_1234 → `mem_write=1`, `mem_addr=0x1234`, `mem_wdata=0xA5A50001`. `req_ready=2'b10` on `mem_ready`.
- **Watchdog:** `TIMEOUT=8`, memory never ready → `timeout_err` pulses once after 8 GRANT cycles. `timeout_count=1`, then the FSM re-arbitrates to the other pending requester.
- **Reset mid-transaction:** assert `rst_n=0` in GRANT → `mem_req=0` and `busy=0` at once. After release, the first grant goes to requester 0.
